// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// The optional divider is enabled by defining MULDIV_DIV_EN.
package mdu_pkg;

  // Operation encoding matches Funct3 of the M extension.
  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } mdu_state_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [1:0] ALUOP_RI      = 2'b10;

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage bundle between the pipeline (master) and the mul/div unit (slave).
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [1:0]      ALUOp;
  logic            RType;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            start;
  logic            flush;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            is_muldiv;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (
    output ALUOp, RType, Funct7, Funct3, start, flush, SrcA, SrcB,
    input  is_muldiv, stall, done, Result
  );

  modport slave (
    input  ALUOp, RType, Funct7, Funct3, start, flush, SrcA, SrcB,
    output is_muldiv, stall, done, Result
  );
endinterface

// File: rtl/mdu_div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per cycle.
// Quotient/remainder outputs are valid only while done_o is high.
module mdu_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            abort_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);
  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] Last = CW'(XLEN - 1);
  localparam logic [CW-1:0] CntOne = CW'(1);

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic            qneg_q, rneg_q;
  logic            dneg, vneg;
  logic [XLEN:0]   shifted, diff;
  logic            fits;
  logic [XLEN-1:0] quo_step, rem_step;

  assign dneg = signed_i & dividend_i[XLEN-1];
  assign vneg = signed_i & divisor_i[XLEN-1];

  // One restoring step: shift in next dividend bit, subtract if it fits.
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = ~diff[XLEN];
    rem_step = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], fits};
  end

  assign busy_o      = busy_q;
  assign done_o      = busy_q && (cnt_q == Last);
  assign quotient_o  = qneg_q ? -quo_step : quo_step;
  assign remainder_o = rneg_q ? -rem_step : rem_step;

  // Load magnitudes on start, iterate while busy; abort clears everything.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dneg ? -dividend_i : dividend_i;
      rem_q  <= '0;
      dvs_q  <= vneg ? -divisor_i : divisor_i;
      qneg_q <= dneg ^ vneg;
      rneg_q <= dneg;
    end else if (busy_q) begin
      quo_q <= quo_step;
      rem_q <= rem_step;
      cnt_q <= cnt_q + CntOne;
      if (cnt_q == Last) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the ALU in EX.
// Define MULDIV_DIV_EN to build the divider; otherwise only multiplies are claimed.
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave mdu
);
  localparam int unsigned NSTEPS = XLEN / MUL_BITS;
  localparam int unsigned CW     = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] MulLast = CW'(NSTEPS - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  localparam logic [1:0] SIdle = StIdle;
  localparam logic [1:0] SMul  = StMul;
  localparam logic [1:0] SDiv  = StDiv;
  localparam logic [1:0] SDone = StDone;

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic                   claim, accept;
  logic                   a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]        mag_a, mag_b;
  logic [XLEN+MUL_BITS-1:0] pp, sum;
  logic [2*XLEN-1:0]      acc_step, prod;

  assign claim = (mdu.ALUOp == ALUOP_RI) && mdu.RType && (mdu.Funct7 == FUNCT7_MULDIV);
`ifdef MULDIV_DIV_EN
  assign mdu.is_muldiv = claim;
`else
  assign mdu.is_muldiv = claim && !mdu.Funct3[2];
`endif
  assign accept    = mdu.start && mdu.is_muldiv;
  assign mdu.stall = ((state_q == SIdle) && accept) || (state_q == SMul) || (state_q == SDiv);
  assign mdu.done  = (state_q == SDone);
  assign mdu.Result = result_q;

  // Operand signedness per op; magnitudes feed the unsigned multiplier.
  always_comb begin
    a_signed = (mdu.Funct3 == OpMulh) || (mdu.Funct3 == OpMulhsu);
    b_signed = (mdu.Funct3 == OpMulh);
`ifdef MULDIV_DIV_EN
    if (mdu.Funct3[2] && !mdu.Funct3[0]) begin
      a_signed = 1'b1;
      b_signed = 1'b1;
    end
`endif
  end

  assign a_neg = a_signed & mdu.SrcA[XLEN-1];
  assign b_neg = b_signed & mdu.SrcB[XLEN-1];
  assign mag_a = a_neg ? -mdu.SrcA : mdu.SrcA;
  assign mag_b = b_neg ? -mdu.SrcB : mdu.SrcB;

  // Shift-add step: low MUL_BITS of acc are the next multiplier digit.
  always_comb begin
    pp       = {{MUL_BITS{1'b0}}, mcand_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]};
    sum      = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
    acc_step = {sum, acc_q[XLEN-1:MUL_BITS]};
    prod     = neg_q ? -acc_step : acc_step;
  end

`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  logic            div_zero, div_ovf, div_start;
  logic            div_busy, div_done;
  logic [XLEN-1:0] div_quo, div_rem, special_res;

  assign div_zero  = (mdu.SrcB == '0);
  assign div_ovf   = !mdu.Funct3[0] && (mdu.SrcA == MinVal) && (mdu.SrcB == '1);
  // Overflow quotient is the dividend itself (min); remainder is 0.
  assign special_res = div_zero ? (mdu.Funct3[1] ? mdu.SrcA : '1)
                                : (mdu.Funct3[1] ? '0 : mdu.SrcA);
  assign div_start = (state_q == SIdle) && accept && mdu.Funct3[2] && !div_zero && !div_ovf
                     && !mdu.flush;

  mdu_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .clk_i       (clk),
    .rst_i       (reset),
    .abort_i     (mdu.flush),
    .start_i     (div_start),
    .signed_i    (!mdu.Funct3[0]),
    .dividend_i  (mdu.SrcA),
    .divisor_i   (mdu.SrcB),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );
`endif

  // Next-state: accept in IDLE, iterate, load Result on completion; flush wins.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      SIdle: begin
        if (accept) begin
          op_d = mdu.Funct3;
          if (!mdu.Funct3[2]) begin
            mcand_d = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            neg_d   = a_neg ^ b_neg;
            cnt_d   = '0;
            state_d = SMul;
          end
`ifdef MULDIV_DIV_EN
          else if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = SDone;
          end else begin
            state_d = SDiv;
          end
`endif
        end
      end
      SMul: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntOne;
        if (cnt_q == MulLast) begin
          result_d = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          cnt_d    = '0;
          state_d  = SDone;
        end
      end
`ifdef MULDIV_DIV_EN
      SDiv: begin
        if (div_done) begin
          result_d = op_q[1] ? div_rem : div_quo;
          state_d  = SDone;
        end else if (!div_busy) begin
          state_d = SIdle;
        end
      end
`endif
      SDone:   state_d = SIdle;
      default: state_d = SIdle;
    endcase
    if (mdu.flush) begin
      state_d  = SIdle;
      result_d = result_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a MUL_BITS=1 and a MUL_BITS=4 instance share stimulus.
module tb_muldiv_unit;
  import mdu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [XLEN-1:0] exp_q[$];

  muldiv_unit_if #(.XLEN(XLEN)) bus ();
  muldiv_unit_if #(.XLEN(XLEN)) bus4 ();

  assign bus4.ALUOp  = bus.ALUOp;
  assign bus4.RType  = bus.RType;
  assign bus4.Funct7 = bus.Funct7;
  assign bus4.Funct3 = bus.Funct3;
  assign bus4.start  = bus.start;
  assign bus4.flush  = bus.flush;
  assign bus4.SrcA   = bus.SrcA;
  assign bus4.SrcB   = bus.SrcB;

  muldiv_unit #(.XLEN(XLEN), .MUL_BITS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  muldiv_unit #(.XLEN(XLEN), .MUL_BITS(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus4)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction for cycle 0 (start high one cycle); push expectation if it completes.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic claim, input logic push,
                       input logic [XLEN-1:0] exp);
    bus.ALUOp  = ALUOP_RI;
    bus.RType  = 1'b1;
    bus.Funct7 = FUNCT7_MULDIV;
    bus.Funct3 = f3;
    bus.SrcA   = a;
    bus.SrcB   = b;
    bus.start  = 1'b1;
    if (push) exp_q.push_back(exp);
    #1;
    check({tag, "_claim"}, 64'(bus.is_muldiv), 64'(claim));
    check({tag, "_stall_c0"}, 64'(bus.stall), 64'(claim));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called at cycle 1; follow both DUTs to done and compare against the scoreboard.
  task automatic run(input string tag, input int exp_cyc, input int exp_cyc4);
    int cyc = 1;
    int dc = 0;
    int dc4 = 0;
    int stall_bad = 0;
    logic [XLEN-1:0] r = '0;
    logic [XLEN-1:0] r4 = '0;
    logic [XLEN-1:0] exp = '0;
    while (cyc <= 60 && (dc == 0 || (exp_cyc4 != 0 && dc4 == 0))) begin
      if (dc == 0) begin
        if (bus.done) begin
          dc = cyc;
          r  = bus.Result;
          if (bus.stall) stall_bad++;
        end else if (!bus.stall) begin
          stall_bad++;
        end
      end
      if (dc4 == 0 && bus4.done) begin
        dc4 = cyc;
        r4  = bus4.Result;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_sb_pending"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    check({tag, "_done_cycle"}, 64'(dc), 64'(exp_cyc));
    check({tag, "_result"}, 64'(r), 64'(exp));
    check({tag, "_stall_profile"}, 64'(stall_bad), 64'd0);
    if (exp_cyc4 != 0) begin
      check({tag, "_r4_done_cycle"}, 64'(dc4), 64'(exp_cyc4));
      check({tag, "_r4_result"}, 64'(r4), 64'(exp));
    end
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    bus.ALUOp  = 2'b00;
    bus.RType  = 1'b0;
    bus.Funct7 = 7'd0;
    bus.Funct3 = 3'd0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.SrcA   = '0;
    bus.SrcB   = '0;

    repeat (3) @(negedge clk);
    check("rst_result", 64'(bus.Result), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_stall", 64'(bus.stall), 64'd0);
    check("rst_result4", 64'(bus4.Result), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue("mul", OpMul, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, 32'hFFFF_FFEB);
    run("mul", 33, 9);
    issue("mulhu", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFE);
    run("mulhu", 33, 9);
    issue("mulh", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000);
    run("mulh", 33, 9);
    issue("mulhsu", OpMulhsu, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run("mulhsu", 33, 9);

    // done is a single pulse and Result holds afterwards.
    check("hold_done_low", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    check("hold_result", 64'(bus.Result), 64'hFFFF_FFFF);

    // ADDI whose imm[11:5] happens to equal the M-extension Funct7.
    bus.ALUOp  = ALUOP_RI;
    bus.RType  = 1'b0;
    bus.Funct7 = FUNCT7_MULDIV;
    bus.Funct3 = 3'b000;
    bus.start  = 1'b1;
    #1;
    check("addi_claim", 64'(bus.is_muldiv), 64'd0);
    check("addi_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    bus.start = 1'b0;
    watch_no_done("addi_no_done", 5);

    // Flush at cycle 10 of a multiply.
    issue("flush", OpMul, 32'd3, 32'd5, 1'b1, 1'b0, '0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_stall_c11", 64'(bus.stall), 64'd0);
    check("flush_done_c11", 64'(bus.done), 64'd0);
    watch_no_done("flush_no_done", 40);
    check("flush_result_kept", 64'(bus.Result), 64'hFFFF_FFFF);

`ifdef MULDIV_DIV_EN
    issue("div", OpDiv, 32'hFFFF_FFEC, 32'd3, 1'b1, 1'b1, 32'hFFFF_FFFA);
    run("div", 33, 33);
    issue("rem", OpRem, 32'hFFFF_FFEC, 32'd3, 1'b1, 1'b1, 32'hFFFF_FFFE);
    run("rem", 33, 33);
    issue("divu0", OpDivu, 32'd5, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run("divu0", 1, 1);
    issue("rem0", OpRem, 32'd5, 32'd0, 1'b1, 1'b1, 32'd5);
    run("rem0", 1, 1);
    issue("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8000_0000);
    run("div_ovf", 1, 1);
    issue("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0);
    run("rem_ovf", 1, 1);

    // Reset at cycle 5 of a divide.
    issue("div_rst", OpDivu, 32'd100, 32'd7, 1'b1, 1'b0, '0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("div_rst_result", 64'(bus.Result), 64'd0);
    check("div_rst_done", 64'(bus.done), 64'd0);
    check("div_rst_stall", 64'(bus.stall), 64'd0);
    watch_no_done("div_rst_no_done", 40);

    issue("divu", OpDivu, 32'd100, 32'd7, 1'b1, 1'b1, 32'd14);
    run("divu", 33, 33);
    issue("remu", OpRemu, 32'd100, 32'd7, 1'b1, 1'b1, 32'd2);
    run("remu", 33, 33);
`else
    issue("div_off", OpDiv, 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b0, '0);
    check("div_off_stall_c1", 64'(bus.stall), 64'd0);
    watch_no_done("div_off_no_done", 40);
    issue("rem_off", OpRemu, 32'd5, 32'd0, 1'b0, 1'b0, '0);
    watch_no_done("rem_off_no_done", 5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit with its own operation decode, parametrised in data width and multiplier radix. Sits beside the ALU in the execute stage. Claims R-type instructions with Funct7 = 0000001, stalls the pipeline while iterating, and returns the XLEN-bit result with a one-cycle done pulse.

## Interface
- XLEN, 32, operand/result width; even, ≥ 8.
- MUL_BITS, 1, multiplier bits retired per cycle; must divide XLEN (1, 2, 4).
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ALUOp  in  2  controller opcode class; 10 = R/I-type.
- RType  in  1  high for OP (R-type) opcode; separates R-type from I-type immediates.
- Funct7  in  7  instruction bits 31:25.
- Funct3  in  3  instruction bits 14:12.
- start  in  1  EX-stage instruction valid.
- flush  in  1  kill in-flight operation (branch/jump redirect).
- SrcA, SrcB  in  XLEN  rs1 / rs2 operands.
- is_muldiv  out  1  combinational: ALUOp==10 && RType && Funct7==0000001.
- stall  out  1  hold pipeline stages at and before EX.
- done  out  1  one-cycle pulse, Result valid.
- Result  out  XLEN  registered result.

## Operation
- Funct3 map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE: on start && is_muldiv, latch operands and op. Multiplies go to MUL. Divides go to DIV, except special cases, which load Result and go straight to DONE.
- Special cases: divisor 0 gives quotient all-ones and remainder SrcA. Signed overflow (min / −1) gives quotient min and remainder 0.
- MUL: unsigned shift-add on magnitudes into a 2·XLEN accumulator, MUL_BITS per cycle, N = XLEN/MUL_BITS cycles. Negate the product if operand signs differ.
  - MUL takes the low half.
  - MULH treats both operands as signed; MULHSU treats A as signed, B as unsigned; MULHU treats both as unsigned. All three take the high half.
- DIV: restoring division, 1 quotient bit per cycle, XLEN cycles, on magnitudes. Quotient is negated if signs differ (DIV). Remainder takes the sign of the dividend (REM). DIVU/REMU are unsigned.
- DONE: done=1 for one cycle, then go to IDLE. start is ignored in DONE because the same instruction is still in EX.
- stall = (state==IDLE && start && is_muldiv) || state==MUL || state==DIV. stall is low in DONE so the pipeline captures Result.
- start while in MUL/DIV is ignored.
- flush in any state forces IDLE next cycle with no done. flush takes priority over start and over completion.
- Reset values: state IDLE, Result 0, done 0, counter 0, accumulators 0. Reset mid-operation aborts with no done.

## Timing
- start accepted at cycle 0 (IDLE).
- Multiply: DONE and done at cycle N+1. With XLEN=32, MUL_BITS=1 that is cycle 33.
- Divide: done at cycle XLEN+1.
- Special-case divide: done at cycle 1.
- Result holds its value until the next done.
- Iteration counter is $clog2(XLEN)+1 bits and never wraps within an operation.

## Configuration
- MULDIV_DIV_EN defined: full M extension as above.
- Not defined: the divider logic is absent. is_muldiv is asserted only for Funct3[2]==0. DIV/DIVU/REM/REMU are not claimed, never stall and never raise done. The DIV state is not built.

## Structure
- Package mdu_pkg holds:
  - mdu_op_e enum (8 ops, Funct3 encoding);
  - mdu_state_e enum;
  - FUNCT7_MULDIV = 7'b0000001;
  - ALUOP_RI = 2'b10.
- Sub-module mdu_div_core holds the restoring divider datapath: start/busy/done, quotient and remainder, sign fix-up. It is instantiated only under MULDIV_DIV_EN.

## Test plan
- MUL 7 × 0xFFFFFFFD (XLEN=32, MUL_BITS=1) → Result 0xFFFFFFEB; done at cycle 33; stall high cycles 0–32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. With MUL_BITS=4, done at cycle 9.
- DIV 0xFFFFFFEC / 3 → 0xFFFFFFFA. REM with the same operands → 0xFFFFFFFE. done at cycle 33.
- Special cases:
  - DIVU 5 / 0 → 0xFFFFFFFF, done at cycle 1.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, done at cycle 1.
  - REM with the same operands → 0.
- flush at cycle 10 of a MUL → IDLE at cycle 11, stall low, no done. reset at cycle 5 of a DIV → Result 0, no done.
- ADDI with imm[11:5]=0000001 (RType=0) → is_muldiv 0, no stall. Without MULDIV_DIV_EN, DIV → is_muldiv 0, no stall.
